fifo_read_stream_adapter: RTL and testbench
===========================================

Name: fifo_read_stream_adapter

Overview:
- Read-domain stage directly downstream of the async FIFO read-pointer/empty-flag logic and its dual-port memory.
- Turns the FIFO read interface (registered empty flag, read enable, memory data with 1-cycle read latency) into a valid/ready stream toward the consumer.
- Uses a 2-entry output buffer so the stream runs at 1 word/cycle with no combinational path from outReadyIn to readEnableOut beyond the credit check.
- Never reads an empty FIFO.

Parameters:
- dataWidth, 8, width of FIFO data word and stream data.

Ports:
- readClkIn  input  1  read-domain clock; all logic on posedge.
- readRstIn  input  1  synchronous, active-high reset.
- fifoEmptyIn  input  1  FIFO empty flag, registered, read domain.
- readEnableOut  output  1  read strobe to the FIFO pointer logic; a word is consumed in every cycle it is high.
- readDataIn  input  dataWidth  memory read data; valid the cycle after readEnableOut was high.
- outDataOut  output  dataWidth  stream data, equal to the buffer head.
- outValidOut  output  1  stream valid.
- outReadyIn  input  1  stream ready from the consumer.
- wordCountOut  output  2  buffer occupancy, 0..2.

Behaviour:
- State:
  - buffer of 2 entries, head/tail index, occupancy occ (0..2);
  - inFlight flag, a 1-bit register meaning "read issued last cycle".
- Reset (readRstIn=1 at posedge):
  - occ=0, inFlight=0, head/tail=0.
  - outValidOut=0, wordCountOut=0, outDataOut=0.
  - readEnableOut is forced 0 in any cycle where readRstIn=1.
- pop = outValidOut & outReadyIn.
- Credit rule: readEnableOut = ~readRstIn & ~fifoEmptyIn & ((occ + inFlight) < 2 | ((occ + inFlight) == 2 & pop)).
  - occ + inFlight never exceeds 2.
- Pipeline:
  - readEnableOut high in cycle N → inFlight=1 in N+1.
  - In N+1, readDataIn is written to buffer[tail] at the end of the cycle.
  - outValidOut=1 from N+2.
  - Minimum latency from fifoEmptyIn falling (seen at cycle N) to outValidOut: 2 cycles.
- Push and pop in the same cycle:
  - occ is unchanged; tail and head both advance (mod 2).
  - Head data updates to the next entry.
- Push with occ==2 cannot occur by construction; the bench asserts this.
- Pop with occ==0 cannot occur because outValidOut = (occ != 0).
- Stream rules:
  - Once outValidOut=1, outDataOut and outValidOut hold stable until pop.
  - No combinational ready→valid dependency.
- Throughput: with outReadyIn=1 and FIFO continuously non-empty, steady state is readEnableOut=1 every cycle and pop every cycle.
- Backpressure:
  - With outReadyIn=0, at most 2 words are drawn from the FIFO, after which readEnableOut=0.
  - Remaining words stay in the FIFO.
- Empty mid-burst:
  - readEnableOut drops in the same cycle fifoEmptyIn=1.
  - Words already in flight or buffered still drain in order.
- Ordering: strict FIFO order; no loss or duplication outside reset.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - The FIFO pointer logic must be reset in the same cycle (system requirement).
- wordCountOut = occ, registered.

Optional Feature:
- Macro: FIFO_STREAM_STALL_COUNT_EN.
- Defined:
  - Adds output stallCountOut [15:0].
  - 16-bit counter increments each cycle outValidOut=1 & outReadyIn=0.
  - Saturates at 16'hFFFF.
  - Cleared by readRstIn.
- Undefined: no port, no counter; all other behaviour identical.

Test Plan:
- Reset: assert readRstIn 3 cycles with fifoEmptyIn=0 → readEnableOut=0, outValidOut=0, wordCountOut=0 throughout; first readEnableOut=1 in the cycle after readRstIn falls.
- Streaming: FIFO preloaded with 0x01..0x10, outReadyIn=1 → readEnableOut high 16 consecutive cycles; outDataOut = 0x01..0x10 in order, one per cycle, with the first outValidOut 2 cycles after the first readEnableOut.
- Backpressure: 5 words 0xA0..0xA4, outReadyIn=0 → exactly 2 read strobes; wordCountOut=2; outDataOut=0xA0 held stable. Then outReadyIn=1 → 0xA0..0xA4 in order; no read while occ+inFlight==2 without a pop.
- Empty mid-burst: fifoEmptyIn rises after 3 reads (0x11,0x12,0x13) → readEnableOut low the same cycle; all 3 words delivered; outValidOut low afterwards; no extra read strobe.
- Random ready: 200 words, outReadyIn random at 50% → scoreboard exact order; no read strobe while fifoEmptyIn=1; occ+inFlight ≤ 2 every cycle.
- Stall count (with FIFO_STREAM_STALL_COUNT_EN): 7 cycles outValidOut=1 & outReadyIn=0 → stallCountOut=7; a saturation test holds the stall 70000 cycles → 16'hFFFF.

Source files
------------

// File: rtl/fifo_read_stream_adapter.sv
// Adapts an async-FIFO read port (registered empty, 1-cycle read latency) to a valid/ready stream
// through a 2-entry buffer; optional stall counter enabled by FIFO_STREAM_STALL_COUNT_EN.
module fifo_read_stream_adapter #(
   parameter int dataWidth = 8
) (
   input  logic                 readClkIn,
   input  logic                 readRstIn,
   input  logic                 fifoEmptyIn,
   output logic                 readEnableOut,
   input  logic [dataWidth-1:0] readDataIn,
   output logic [dataWidth-1:0] outDataOut,
   output logic                 outValidOut,
   input  logic                 outReadyIn,
   output logic [1:0]           wordCountOut
`ifdef FIFO_STREAM_STALL_COUNT_EN
   ,
   output logic [15:0]          stallCountOut
`endif
);

   logic [dataWidth-1:0] mem_q [2];
   logic                 head_q;
   logic                 tail_q;
   logic [1:0]           occ_q;
   logic [1:0]           occ_d;
   logic                 valid_q;
   logic                 in_flight_q;
   logic                 pop;
   logic                 push;
   logic [1:0]           credit;

   // A word read last cycle lands in the buffer now, so it already holds a slot in the credit.
   assign pop    = valid_q & outReadyIn;
   assign push   = in_flight_q;
   assign credit = occ_q + {1'b0, in_flight_q};

   assign readEnableOut = ~readRstIn & ~fifoEmptyIn &
                          ((credit < 2'd2) | ((credit == 2'd2) & pop));

   // NOTE: give every combinational output a default before the case so no latch is inferred.
   always_comb begin
      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the two data entries are reset
   // so the stream data reads as zero out of reset (cheap at this depth).
   always_ff @(posedge readClkIn) begin
      if (readRstIn) begin
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         occ_q       <= 2'd0;
         valid_q     <= 1'b0;
         in_flight_q <= 1'b0;
      end else begin
         in_flight_q <= readEnableOut;
         occ_q       <= occ_d;
         valid_q     <= (occ_d != 2'd0);
         if (push) begin
            mem_q[tail_q] <= readDataIn;
            tail_q        <= ~tail_q;
         end
         if (pop) begin
            head_q <= ~head_q;
         end
      end
   end

   assign outDataOut   = mem_q[head_q];
   assign outValidOut  = valid_q;
   assign wordCountOut = occ_q;

`ifdef FIFO_STREAM_STALL_COUNT_EN
   logic [15:0] stall_q;

   // Counts cycles the consumer holds off a valid word; sticks at all-ones.
   always_ff @(posedge readClkIn) begin
      if (readRstIn) begin
         stall_q <= 16'd0;
      end else if (valid_q & ~outReadyIn & (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stallCountOut = stall_q;
`endif

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench for fifo_read_stream_adapter: queue-based FIFO source, buffer-occupancy model and scoreboard.
module tb_fifo_read_stream_adapter;

   localparam int DW = 8;

   logic          readClkIn = 1'b0;
   logic          readRstIn = 1'b1;
   logic          fifoEmptyIn = 1'b1;
   logic          readEnableOut;
   logic [DW-1:0] readDataIn = '0;
   logic [DW-1:0] outDataOut;
   logic          outValidOut;
   logic          outReadyIn = 1'b0;
   logic [1:0]    wordCountOut;
`ifdef FIFO_STREAM_STALL_COUNT_EN
   logic [15:0]   stallCountOut;
`endif

   fifo_read_stream_adapter #(.dataWidth(DW)) dut (
      .readClkIn     (readClkIn),
      .readRstIn     (readRstIn),
      .fifoEmptyIn   (fifoEmptyIn),
      .readEnableOut (readEnableOut),
      .readDataIn    (readDataIn),
      .outDataOut    (outDataOut),
      .outValidOut   (outValidOut),
      .outReadyIn    (outReadyIn),
      .wordCountOut  (wordCountOut)
`ifdef FIFO_STREAM_STALL_COUNT_EN
      ,
      .stallCountOut (stallCountOut)
`endif
   );

   always #5 readClkIn = ~readClkIn;

   int n_checks = 0;
   int n_fail   = 0;

   // Environment: FIFO contents, plus the word presented on readDataIn after a read.
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] sent_q[$];
   logic [DW-1:0] pend_word = '0;
   bit            have_word = 1'b0;
   bit            force_empty = 1'b0;

   // Model: words sitting in the output buffer, a read in flight, delivered words.
   logic [DW-1:0] mdl_buf[$];
   bit            mdl_inflight = 1'b0;
   logic [DW-1:0] mdl_word = '0;
   logic [DW-1:0] got_q[$];
   logic [15:0]   mdl_stall = '0;
   bit            prev_re = 1'b0;

   int cyc = 0;
   int rd_cnt = 0;
   int first_re = -1;
   int last_re = -1;
   int first_valid = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      src_q.push_back(w);
      sent_q.push_back(w);
   endtask

   task automatic new_scenario();
      got_q.delete();
      sent_q.delete();
      rd_cnt = 0;
      first_re = -1;
      last_re = -1;
      first_valid = -1;
   endtask

   // One clock cycle: drive inputs at negedge, compare against the model, then advance the model
   // to what the coming posedge must produce.
   task automatic tick(input bit rst, input bit rdy);
      bit exp_valid;
      bit exp_re;
      bit pop_m;
      int credit;
      @(negedge readClkIn);
      readRstIn   = rst;
      outReadyIn  = rdy;
      readDataIn  = have_word ? pend_word : DW'($urandom);
      fifoEmptyIn = force_empty || (src_q.size() == 0);
      #1;
      exp_valid = (mdl_buf.size() != 0);
      credit    = mdl_buf.size() + int'(mdl_inflight);
      pop_m     = exp_valid && rdy;
      exp_re    = !rst && !fifoEmptyIn && ((credit < 2) || (credit == 2 && pop_m));

      check("out_valid", 32'(outValidOut), 32'(exp_valid));
      check("word_count", 32'(wordCountOut), 32'(mdl_buf.size()));
      check("read_enable", 32'(readEnableOut), 32'(exp_re));
      if (exp_valid) check("out_data", 32'(outDataOut), 32'(mdl_buf[0]));
      check("credit_bound", 32'((int'(wordCountOut) + int'(prev_re)) <= 2), 32'd1);
      check("push_into_full", 32'(prev_re && (wordCountOut == 2'd2)), 32'd0);
      check("read_while_empty", 32'(readEnableOut && fifoEmptyIn), 32'd0);
`ifdef FIFO_STREAM_STALL_COUNT_EN
      check("stall_count", 32'(stallCountOut), 32'(mdl_stall));
`endif

      if (readEnableOut) begin
         rd_cnt++;
         if (first_re < 0) first_re = cyc;
         last_re = cyc;
      end
      if (exp_valid && first_valid < 0) first_valid = cyc;

      if (rst) begin
         mdl_buf.delete();
         mdl_inflight = 1'b0;
         mdl_stall = '0;
      end else begin
         if (exp_valid && !rdy && mdl_stall != 16'hFFFF) mdl_stall = mdl_stall + 16'd1;
         if (pop_m) got_q.push_back(mdl_buf.pop_front());
         if (mdl_inflight) mdl_buf.push_back(mdl_word);
         mdl_inflight = readEnableOut;
      end

      if (readEnableOut && src_q.size() != 0) begin
         pend_word = src_q.pop_front();
         mdl_word  = pend_word;
         have_word = 1'b1;
      end else begin
         have_word = 1'b0;
      end
      if (rst) have_word = 1'b0;
      prev_re = readEnableOut;
      cyc++;
   endtask

   task automatic drain(input bit rdy_random);
      int n = 0;
      while ((src_q.size() != 0 || mdl_buf.size() != 0 || mdl_inflight) && n < 2000) begin
         tick(1'b0, rdy_random ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
      check("drain_timeout", 32'(n < 2000), 32'd1);
      repeat (3) tick(1'b0, 1'b1);
   endtask

   task automatic check_order(input string name);
      check({name, "_count"}, 32'(got_q.size()), 32'(sent_q.size()));
      for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
         check({name, "_order"}, 32'(got_q[i]), 32'(sent_q[i]));
   endtask

   initial begin
      @(posedge readClkIn);
      #1;

      // Reset held 3 cycles with a non-empty FIFO.
      new_scenario();
      push_word(8'h77);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1);
         check("rst_read_enable", 32'(readEnableOut), 32'd0);
         check("rst_valid", 32'(outValidOut), 32'd0);
         check("rst_count", 32'(wordCountOut), 32'd0);
      end
      check("rst_data", 32'(outDataOut), 32'd0);
      tick(1'b0, 1'b1);
      check("read_after_rst", 32'(readEnableOut), 32'd1);
      drain(1'b0);
      check_order("rst_word");

      // Streaming 0x01..0x10 with the consumer always ready.
      new_scenario();
      for (int i = 1; i <= 16; i++) push_word(DW'(i));
      drain(1'b0);
      check("stream_reads", 32'(rd_cnt), 32'd16);
      check("stream_consecutive", 32'(last_re - first_re), 32'd15);
      check("stream_latency", 32'(first_valid - first_re), 32'd2);
      check("stream_words", 32'(got_q.size()), 32'd16);
      for (int i = 0; i < got_q.size() && i < 16; i++)
         check("stream_data", 32'(got_q[i]), 32'(i + 1));

      // Backpressure: 5 words, consumer stalled.
      new_scenario();
      for (int i = 0; i < 5; i++) push_word(8'hA0 + DW'(i));
      repeat (6) tick(1'b0, 1'b0);
      check("bp_reads", 32'(rd_cnt), 32'd2);
      check("bp_count", 32'(wordCountOut), 32'd2);
      check("bp_head", 32'(outDataOut), 32'hA0);
      check("bp_left_in_fifo", 32'(src_q.size()), 32'd3);
      drain(1'b0);
      check("bp_total_reads", 32'(rd_cnt), 32'd5);
      check_order("bp");

      // FIFO runs empty after three words.
      new_scenario();
      push_word(8'h11);
      push_word(8'h12);
      push_word(8'h13);
      drain(1'b0);
      repeat (4) tick(1'b0, 1'b1);
      check("empty_reads", 32'(rd_cnt), 32'd3);
      check("empty_valid_after", 32'(outValidOut), 32'd0);
      check_order("empty");

      // Random ready, random refills and random empty flag, 200 words.
      new_scenario();
      for (int n = 0; n < 6000 && sent_q.size() < 200; n++) begin
         if ($urandom_range(0, 9) < 7) push_word(DW'($urandom));
         force_empty = ($urandom_range(0, 9) == 0);
         tick(1'b0, 1'($urandom_range(0, 1)));
      end
      force_empty = 1'b0;
      drain(1'b1);
      check("rand_sent", 32'(sent_q.size()), 32'd200);
      check_order("rand");

`ifdef FIFO_STREAM_STALL_COUNT_EN
      // Stall counter: 7 stalled cycles, then saturation.
      new_scenario();
      tick(1'b1, 1'b0);
      push_word(8'h5A);
      repeat (10) tick(1'b0, 1'b0);
      check("stall_seven", 32'(stallCountOut), 32'd7);
      repeat (70000) tick(1'b0, 1'b0);
      check("stall_saturate", 32'(stallCountOut), 32'hFFFF);
      drain(1'b0);
      check_order("stall");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
